load_store_unit: RTL and testbench
==================================

# load_store_unit

Core-side load/store master that drives the word-addressed data memory (combinational read, synchronous word write, single write enable). It accepts byte-addressed RV32I load/store requests from the execute stage and converts them into word accesses. It performs sign/zero extension for loads and read-modify-write for byte and halfword stores. It returns exactly one response per accepted request.

## Interface
- ADDR_W, 13, word-address bits forwarded to memory (8192 words); mem_addr[31:ADDR_W] driven 0
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse, no backpressure
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request rejected, no memory write performed
- mem_we  out  1  memory word write enable
- mem_addr  out  32  word address = req_addr[ADDR_W+1:2]
- mem_wd  out  32  word write data
- mem_rd  in  32  word read data, combinational from mem_addr

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, capture the request; mem_addr and byte offset registered.
  - Load: go to READ.
  - SW: go to WRITE.
  - SB/SH: go to READ.
  - Error: go to RESP with err set.
- READ: latch mem_rd into a word register.
  - Load: go to RESP.
  - Sub-word store: go to WRITE.
- WRITE: mem_we=1 for exactly one cycle; mem_wd = merged word; go to RESP.
- RESP: resp_valid=1 for one cycle; return to IDLE.
- Byte order is little-endian. The byte lane is addr[1:0]; the halfword lane is addr[1].
- LB/LH sign-extend. LBU/LHU zero-extend. LW returns the word unchanged.
- Sub-word store merge:
  - Read word with the target lane replaced by req_wdata[7:0] or req_wdata[15:0].
  - All other bytes unchanged.
- Invalid request → resp_err=1, no memory access:
  - funct3 011, 110 or 111;
  - store with funct3 100 or 101.
- Misalignment handling is set under Configuration.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wd=0.
- Accept edge = k. resp_valid is high in the cycle after edge:
  - load: k+2
  - SW: k+2
  - SB/SH: k+3
  - error: k+1
- req_ready is low from edge k until the RESP cycle completes. The next accept is possible on the edge ending the IDLE cycle after RESP.
- Requests are never accepted while resp_valid=1.
- mem_we is decoded from state==WRITE only. It is never high in any other state or during reset.
- mem_addr is stable from edge k through the WRITE cycle. The write lands on the edge ending WRITE.
- resp_rdata and resp_err are valid only while resp_valid=1. They are held until the next response.
- Reset asserted mid-operation: immediate return to IDLE, mem_we drops asynchronously, the pending write is aborted, and no response is issued.

## Configuration
- MISALIGN_TRAP_EN defined:
  - H/HU with addr[0]=1, or W with addr[1:0]≠0, is an error.
  - The unit goes IDLE→RESP with resp_err=1 and resp_rdata=0. No memory access.
- Not defined: misaligned low bits are ignored.
  - W ignores addr[1:0]; H/HU ignores addr[0].
  - The access proceeds on the aligned lane. resp_err is raised only for invalid funct3.

## Structure
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum;
  - request struct (we, funct3, addr, wdata).
- Sub-module lsu_align: purely combinational load extraction/extension and store merge. It takes the word, offset, funct3 and wdata.
- The FSM and registers stay in load_store_unit.

## Test plan
- Preload word 0x8877_6655 at byte addr 0x10. LB 0x13 → resp_rdata 0xFFFF_FF88; LBU 0x13 → 0x0000_0088; LH 0x12 → 0xFFFF_8877; LHU 0x10 → 0x0000_6655; each response 2 cycles after accept.
- SB 0xAB to 0x11 over 0x8877_6655 → exactly one mem_we pulse 2 cycles after accept, with mem_wd 0x8877_AB55; a following LW 0x10 returns 0x8877_AB55.
- SW 0xDEAD_BEEF to 0x20 → mem_we the cycle after accept, with mem_addr 0x8 and mem_wd 0xDEAD_BEEF; resp_err 0; resp_rdata 0.
- LW 0x22:
  - with MISALIGN_TRAP_EN → resp_err 1 one cycle after accept, no mem access;
  - without it → returns the word at 0x20.
- funct3 011 load and funct3 100 store → resp_err 1, mem_we never asserted.
- Assert rst_n low during the WRITE state of an SB → mem_we falls immediately, memory unchanged, no resp_valid, req_ready 1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// MISALIGN_TRAP_EN: when defined, misaligned H/HU/W accesses are rejected with an error.
package lsu_pkg;

    localparam int ADDR_W = 13;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic lsu_req_err(input logic we, input logic [2:0] funct3,
                                         input logic [1:0] offset);
        logic err;
        err = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
              (we && ((funct3 == F3_BU) || (funct3 == F3_HU)));
`ifdef MISALIGN_TRAP_EN
        err = err || (((funct3 == F3_H) || (funct3 == F3_HU)) && offset[0]) ||
                     ((funct3 == F3_W) && (offset != 2'b00));
`else
        // Low address bits are simply dropped, so the offset never causes an error.
        err = err || (1'b0 & (^offset));
`endif
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension and
// sub-word store merge into a previously read word (little-endian lanes).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = word >> {offset, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = offset[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = word;
        endcase
    end

    // Each byte lane takes new data only when it is covered by the store size.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic byte_hit;
        logic half_hit;
        assign byte_hit = (funct3[1:0] == 2'b00) && (offset == 2'(gi));
        assign half_hit = (funct3[1:0] == 2'b01) && (offset[1] == 1'(gi / 2));
        always_comb begin
            if (byte_hit) begin
                store_word[gi*8 +: 8] = wdata[7:0];
            end else if (half_hit) begin
                store_word[gi*8 +: 8] = wdata[(gi % 2)*8 +: 8];
            end else if (funct3[1:0] == 2'b10) begin
                store_word[gi*8 +: 8] = wdata[gi*8 +: 8];
            end else begin
                store_word[gi*8 +: 8] = word[gi*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed RV32I load/store front end driving a word-addressed data memory.
// Build option MISALIGN_TRAP_EN (see lsu_pkg) turns misaligned H/W accesses into errors.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    lsu_state_e  state_q, state_d;
    lsu_req_t    req_q, req_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] mem_wd_q, mem_wd_d;

    logic [31:0] load_data;
    logic [31:0] store_word;

    lsu_align u_align (
        .word       (mem_rd),
        .offset     (req_q.addr[1:0]),
        .funct3     (req_q.funct3),
        .wdata      (req_q.wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_wd_d     = mem_wd_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
                    if (lsu_req_err(req_we, req_funct3, req_addr[1:0])) begin
                        state_d      = ST_RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        state_d  = ST_WRITE;
                        mem_wd_d = req_wdata;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (req_q.we) begin
                    state_d  = ST_WRITE;
                    mem_wd_d = store_word;
                end else begin
                    state_d      = ST_RESP;
                    resp_rdata_d = load_data;
                    resp_err_d   = 1'b0;
                end
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_wd_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_wd_q     <= mem_wd_d;
        end
    end

    // Address bits above the memory's range are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_q.addr[31:ADDR_W+2];

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_we     = (state_q == ST_WRITE);
    assign mem_addr   = {{(32-ADDR_W){1'b0}}, req_q.addr[ADDR_W+1:2]};
    assign mem_wd     = mem_wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-array reference model,
// plus directed literal checks of the documented examples.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    // Data memory: combinational read, synchronous word write.
    logic [31:0] tb_mem [0:8191];
    assign mem_rd = tb_mem[mem_addr[12:0]];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr[12:0]] <= mem_wd;
    end

    // Reference model state: memory as a flat byte array.
    logic [7:0] shadow [0:32767];

    int n_vec = 0;
    int n_err = 0;

    // Expectations for the transaction in flight.
    bit          active = 1'b0;
    bit          chk_en = 1'b1;
    int          idx;
    int          e_lat;
    int          e_wr;
    logic        e_err;
    logic [31:0] e_rdata;
    logic [31:0] e_wd;
    logic [31:0] e_maddr;
    logic [31:0] got_rdata;
    logic        got_err;
    int          got_lat;
    logic [31:0] got_wd;
    logic [31:0] got_maddr;
    int          wr_seen;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] shadow_word(input logic [12:0] w);
        return {shadow[{w, 2'b11}], shadow[{w, 2'b10}], shadow[{w, 2'b01}], shadow[{w, 2'b00}]};
    endfunction

    // Behavioural model: applies a request to the byte array and predicts the response.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        int          size;
        logic [14:0] base;
        logic [31:0] v;
        e_err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && (f3 == 3'd4 || f3 == 3'd5));
`ifdef MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) e_err = 1'b1;
        if (f3 == 3'd2 && a[1:0] != 2'b00) e_err = 1'b1;
`endif
        size    = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        base    = a[14:0] & ~15'(size - 1);
        e_maddr = {17'h0, a[14:2]};
        e_rdata = 32'h0;
        e_wd    = 32'h0;
        e_wr    = -1;
        if (e_err) begin
            e_lat = 0;
        end else if (!we) begin
            e_lat = 1;
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(shadow[base + 15'(i)]) << (8 * i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
            e_rdata = v;
        end else begin
            e_lat = (size == 4) ? 1 : 2;
            e_wr  = e_lat - 1;
            for (int i = 0; i < size; i++) shadow[base + 15'(i)] = wd[8*i +: 8];
            e_wd = shadow_word(a[14:2]);
        end
    endtask

    // Compare process: checks every output on every cycle while out of reset.
    initial forever begin
        @(negedge clk);
        if (rst_n && chk_en) begin
            if (active) begin
                chk("req_ready_busy", 32'(req_ready), 32'd0);
                chk("resp_valid", 32'(resp_valid), 32'(idx == e_lat));
                chk("mem_we", 32'(mem_we), 32'(idx == e_wr));
                chk("mem_addr", mem_addr, e_maddr);
                if (mem_we) begin
                    chk("mem_wd", mem_wd, e_wd);
                    got_wd    = mem_wd;
                    got_maddr = mem_addr;
                    wr_seen++;
                end
                if (resp_valid) begin
                    chk("resp_rdata", resp_rdata, e_rdata);
                    chk("resp_err", 32'(resp_err), 32'(e_err));
                    got_rdata = resp_rdata;
                    got_err   = resp_err;
                    got_lat   = idx;
                    active    = 1'b0;
                end
                idx++;
            end else begin
                chk("idle_req_ready", 32'(req_ready), 32'd1);
                chk("idle_resp_valid", 32'(resp_valid), 32'd0);
                chk("idle_mem_we", 32'(mem_we), 32'd0);
            end
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        int n;
        @(negedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n == 10) chk("accept_timeout", 32'(req_ready), 32'd1);
        model(we, f3, a, wd);
        got_lat = -1;
        wr_seen = 0;
        got_rdata = 32'hxxxx_xxxx;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        idx       = 0;
        active    = 1'b1;
        n = 0;
        while (active && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (active) begin
            chk("resp_timeout", 32'(resp_valid), 32'd1);
            active = 1'b0;
        end
        $display("txn we=%0d f3=%0d addr=%h wdata=%h -> err=%0d rdata=%h lat=%0d",
                 we, f3, a, wd, got_err, got_rdata, got_lat);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] keep;
        logic [2:0]  f3;
        logic        we;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 8192; i++) tb_mem[i] = 32'h0;
        for (int i = 0; i < 32768; i++) shadow[i] = 8'h0;
        for (int w = 0; w < 64; w++) begin
            a = $urandom;
            tb_mem[w] = a;
            for (int b = 0; b < 4; b++) shadow[w*4 + b] = a[8*b +: 8];
        end
        a = 32'h8877_6655;
        tb_mem[4] = a;
        for (int b = 0; b < 4; b++) shadow[16 + b] = a[8*b +: 8];

        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        #20;
        rst_n = 1'b1;

        // Documented examples with hand-computed results.
        do_req(1'b0, 3'b000, 32'h13, 32'h0);
        chk("lb_13", got_rdata, 32'hFFFF_FF88);
        chk("lb_lat", 32'(got_lat), 32'd1);
        do_req(1'b0, 3'b100, 32'h13, 32'h0);
        chk("lbu_13", got_rdata, 32'h0000_0088);
        do_req(1'b0, 3'b001, 32'h12, 32'h0);
        chk("lh_12", got_rdata, 32'hFFFF_8877);
        do_req(1'b0, 3'b101, 32'h10, 32'h0);
        chk("lhu_10", got_rdata, 32'h0000_6655);
        do_req(1'b1, 3'b000, 32'h11, 32'h0000_00AB);
        chk("sb_wd", got_wd, 32'h8877_AB55);
        chk("sb_we_count", 32'(wr_seen), 32'd1);
        chk("sb_lat", 32'(got_lat), 32'd2);
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        chk("lw_after_sb", got_rdata, 32'h8877_AB55);
        do_req(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF);
        chk("sw_addr", got_maddr, 32'h8);
        chk("sw_wd", got_wd, 32'hDEAD_BEEF);
        chk("sw_err", 32'(got_err), 32'd0);
        chk("sw_rdata", got_rdata, 32'h0);
        do_req(1'b0, 3'b010, 32'h22, 32'h0);
`ifdef MISALIGN_TRAP_EN
        chk("lw_22_err", 32'(got_err), 32'd1);
        chk("lw_22_lat", 32'(got_lat), 32'd0);
`else
        chk("lw_22_data", got_rdata, 32'hDEAD_BEEF);
`endif
        do_req(1'b0, 3'b011, 32'h10, 32'h0);
        chk("f3_011_err", 32'(got_err), 32'd1);
        chk("f3_011_lat", 32'(got_lat), 32'd0);
        do_req(1'b1, 3'b100, 32'h10, 32'h1234_5678);
        chk("st_f3_100_err", 32'(got_err), 32'd1);
        chk("st_f3_100_no_we", 32'(wr_seen), 32'd0);

        // Reset during the WRITE cycle of a byte store must abort the write.
        keep = shadow_word(13'h0C);
        chk_en = 1'b0;
        @(negedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h31;
        req_wdata  = 32'h0000_005A;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("abort_we_before", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_we_drop", 32'(mem_we), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_mem_wd", mem_wd, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_mem_unchanged", tb_mem[12], keep);

        // Random traffic.
        for (int t = 0; t < 300; t++) begin
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                             : 3'($urandom_range(0, 2));
            if (!we && $urandom_range(0, 2) == 0) f3 = f3 | 3'b100;
            a = $urandom;
            a[14:0] = 15'($urandom_range(0, 255));
            do_req(we, f3, a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
